// File: rtl/day_display_pkg.sv
// Shared letter codes, segment patterns and scan-state type for the day display.
// The day-setting stage uses the same letter-code constants.
package day_display_pkg;

    localparam logic [3:0] LTR_SPACE = 4'd0;
    localparam logic [3:0] LTR_A     = 4'd1;
    localparam logic [3:0] LTR_D     = 4'd2;
    localparam logic [3:0] LTR_E     = 4'd3;
    localparam logic [3:0] LTR_F     = 4'd4;
    localparam logic [3:0] LTR_H     = 4'd5;
    localparam logic [3:0] LTR_I     = 4'd6;
    localparam logic [3:0] LTR_N     = 4'd7;
    localparam logic [3:0] LTR_O     = 4'd8;
    localparam logic [3:0] LTR_P     = 4'd9;
    localparam logic [3:0] LTR_R     = 4'd10;
    localparam logic [3:0] LTR_S     = 4'd11;
    localparam logic [3:0] LTR_T     = 4'd12;
    localparam logic [3:0] LTR_U     = 4'd13;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_SPACE = 7'h00;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_I     = 7'h30;
    localparam logic [6:0] SEG_N     = 7'h54;
    localparam logic [6:0] SEG_O     = 7'h5C;
    localparam logic [6:0] SEG_P     = 7'h73;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_S     = 7'h6D;
    localparam logic [6:0] SEG_T     = 7'h78;
    localparam logic [6:0] SEG_U     = 7'h3E;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam logic [3:0] AN_ALL_OFF  = 4'hF;
    localparam logic [6:0] SEG_ALL_OFF = 7'h7F;

    typedef enum logic {
        SCAN_GUARD = 1'b0,
        SCAN_DRIVE = 1'b1
    } scanState_e;

endpackage

// File: rtl/letter_seg_decode.sv
// Combinational letter-code to active-high 7-segment pattern decoder.
// Undefined codes render as a dash.
module letter_seg_decode
    import day_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        // NOTE: every path assigns pattern (default first), so no latch is inferred.
        pattern = SEG_DASH;
        case (code)
            LTR_SPACE: pattern = SEG_SPACE;
            LTR_A:     pattern = SEG_A;
            LTR_D:     pattern = SEG_D;
            LTR_E:     pattern = SEG_E;
            LTR_F:     pattern = SEG_F;
            LTR_H:     pattern = SEG_H;
            LTR_I:     pattern = SEG_I;
            LTR_N:     pattern = SEG_N;
            LTR_O:     pattern = SEG_O;
            LTR_P:     pattern = SEG_P;
            LTR_R:     pattern = SEG_R;
            LTR_S:     pattern = SEG_S;
            LTR_T:     pattern = SEG_T;
            LTR_U:     pattern = SEG_U;
            default:   pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/day_display_scan.sv
// Scanned 4-digit common-anode driver for day-of-week letters with guard gaps
// and frame-boundary updates. Define DAY_DISPLAY_BLINK_EN for edit blinking.
module day_display_scan
    import day_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] letter0,
    input  logic [3:0] letter1,
    input  logic [3:0] letter2,
    input  logic [3:0] letter3,
    input  logic       blank,
    input  logic       edit,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       frame
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

    scanState_e      state, stateNext;
    logic [CW-1:0]   counter;
    logic [1:0]      digit;
    logic            slotEnd, boundary;
    logic [3:0][3:0] letterIn, shadow, active;
    logic            pending;
    logic [6:0]      segPattern;
    logic            blinkOff;

    assign letterIn = {letter3, letter2, letter1, letter0};

    always_comb begin
        stateNext = state;
        slotEnd   = (counter == SLOT_LAST);
        boundary  = 1'b0;
        case (state)
            SCAN_GUARD: if (counter == GUARD_LAST) stateNext = SCAN_DRIVE;
            SCAN_DRIVE: begin
                if (slotEnd) stateNext = SCAN_GUARD;
                boundary = slotEnd && (digit == 2'd3);
            end
            default: stateNext = SCAN_GUARD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SCAN_GUARD;
            counter <= '0;
            digit   <= 2'd0;
        end else begin
            state   <= stateNext;
            counter <= slotEnd ? '0 : counter + 1'b1;
            if (slotEnd) digit <= digit + 2'd1;
        end
    end

    // NOTE: the letter stores are a handful of flops, so they are reset to
    // space rather than left uninitialised like a RAM would be.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load) shadow <= letterIn;
            if (boundary) begin
                // A load in the boundary cycle bypasses shadow so it is not lost.
                if (load)         active <= letterIn;
                else if (pending) active <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    letter_seg_decode u_decode (
        .code    (active[digit]),
        .pattern (segPattern)
    );

`ifdef DAY_DISPLAY_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] frameCnt;
    logic          phaseOff;

    // Leaving edit restarts the blink cycle so the next edit begins "on".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frameCnt <= '0;
            phaseOff <= 1'b0;
        end else if (!edit) begin
            frameCnt <= '0;
            phaseOff <= 1'b0;
        end else if (boundary) begin
            if (frameCnt == FW'(BLINK_FRAMES - 1)) begin
                frameCnt <= '0;
                phaseOff <= ~phaseOff;
            end else begin
                frameCnt <= frameCnt + 1'b1;
            end
        end
    end

    assign blinkOff = edit & phaseOff;
`else
    localparam int unusedBlinkFrames = BLINK_FRAMES;
    logic unusedEdit;
    assign unusedEdit = edit;
    assign blinkOff   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_n  <= AN_ALL_OFF;
            seg_n <= SEG_ALL_OFF;
            frame <= 1'b0;
        end else begin
            frame <= boundary;
            if (blank || state == SCAN_GUARD) begin
                an_n  <= AN_ALL_OFF;
                seg_n <= SEG_ALL_OFF;
            end else begin
                an_n  <= ~(4'b1000 >> digit);
                seg_n <= blinkOff ? SEG_ALL_OFF : ~segPattern;
            end
        end
    end

endmodule

// File: tb/tb_day_display_scan.sv
// Self-checking bench for day_display_scan against a frame-position reference model.
// Blink checks are built when DAY_DISPLAY_BLINK_EN is defined.
module tb_day_display_scan;

    localparam int REFRESH_DIV  = 8;
    localparam int GUARD        = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_LEN    = 4 * REFRESH_DIV;

    logic       clk = 1'b0;
    logic       reset, load, blank, edit;
    logic [3:0] letter0, letter1, letter2, letter3;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       frame;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    day_display_scan #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD        (GUARD),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .letter0 (letter0),
        .letter1 (letter1),
        .letter2 (letter2),
        .letter3 (letter3),
        .blank   (blank),
        .edit    (edit),
        .an_n    (an_n),
        .seg_n   (seg_n),
        .frame   (frame)
    );

    // Reference model: position within the frame is plain arithmetic on a cycle count.
    int         cyc;
    logic [3:0] mShadow [4];
    logic [3:0] mActive [4];
    bit         mPending;
    int         mFrames;
    bit         mOff;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic       expFrame;

    function automatic logic [6:0] segOf(input logic [3:0] c);
        case (c)
            4'd0:  return 7'h00;
            4'd1:  return 7'h77;
            4'd2:  return 7'h5E;
            4'd3:  return 7'h79;
            4'd4:  return 7'h71;
            4'd5:  return 7'h76;
            4'd6:  return 7'h30;
            4'd7:  return 7'h54;
            4'd8:  return 7'h5C;
            4'd9:  return 7'h73;
            4'd10: return 7'h50;
            4'd11: return 7'h6D;
            4'd12: return 7'h78;
            4'd13: return 7'h3E;
            default: return 7'h40;
        endcase
    endfunction

    task automatic modelReset();
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            mShadow[i] = 4'd0;
            mActive[i] = 4'd0;
        end
        mPending = 1'b0;
        mFrames  = 0;
        mOff     = 1'b0;
        expAn    = 4'hF;
        expSeg   = 7'h7F;
        expFrame = 1'b0;
    endtask

    // Predict the registered outputs after the coming edge from the current inputs.
    task automatic modelAdvance();
        int pos, d, s;
        bit bnd;
        logic [3:0] inL [4];
        inL = '{letter0, letter1, letter2, letter3};
        pos = cyc % FRAME_LEN;
        d   = pos / REFRESH_DIV;
        s   = pos % REFRESH_DIV;
        bnd = (pos == FRAME_LEN - 1);
        expFrame = bnd;
        expAn    = 4'hF;
        expSeg   = 7'h7F;
        if (!blank && s >= GUARD) begin
            expAn[3-d] = 1'b0;
            if (!(edit && mOff)) expSeg = ~segOf(mActive[d]);
        end
        if (bnd) begin
            if (load)          mActive = inL;
            else if (mPending) mActive = mShadow;
            mPending = 1'b0;
        end else if (load) begin
            mPending = 1'b1;
        end
        if (load) mShadow = inL;
`ifdef DAY_DISPLAY_BLINK_EN
        if (!edit) begin
            mFrames = 0;
            mOff    = 1'b0;
        end else if (bnd) begin
            mFrames++;
            if (mFrames == BLINK_FRAMES) begin
                mFrames = 0;
                mOff    = !mOff;
            end
        end
`endif
        cyc++;
    endtask

    task automatic tick();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic setLetters(input logic [3:0] a, b, c, d);
        letter0 = a; letter1 = b; letter2 = c; letter3 = d;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        load = 0; blank = 0; edit = 0;
        setLetters(4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b1;
        #12;
        total++; if (an_n !== 4'hF)  begin bad++; $display("FAIL reset_an an_n=%b want 1111", an_n); end
        total++; if (seg_n !== 7'h7F) begin bad++; $display("FAIL reset_seg seg_n=%h want 7f", seg_n); end
        total++; if (frame !== 1'b0) begin bad++; $display("FAIL reset_frame frame=%b want 0", frame); end
        doReset();
    endtask

    task automatic test_idle_scan();
        int pulses = 0;
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            tick();
            if (frame === 1'b1) pulses++;
            total++;
            if (an_n !== expAn || seg_n !== expSeg || frame !== expFrame) begin
                bad++;
                $display("FAIL idle cyc=%0d an_n=%b want %b seg_n=%h want %h frame=%b want %b",
                         cyc, an_n, expAn, seg_n, expSeg, frame, expFrame);
            end
        end
        total++;
        if (pulses !== 2) begin bad++; $display("FAIL idle_frames pulses=%0d want 2", pulses); end
    endtask

    task automatic runCompare(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            total++;
            if (an_n !== expAn || seg_n !== expSeg || frame !== expFrame) begin
                bad++;
                $display("FAIL %s cyc=%0d an_n=%b want %b seg_n=%h want %h frame=%b want %b",
                         name, cyc, an_n, expAn, seg_n, expSeg, frame, expFrame);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        logic [6:0] seen [4];
        runCompare("tue_pre", 11);
        setLetters(4'd12, 4'd13, 4'd3, 4'd0);
        load = 1'b1; tick(); load = 1'b0;
        while (cyc % FRAME_LEN != 0) runCompare("tue_wait", 1);
        for (int i = 0; i < FRAME_LEN + 1; i++) begin
            runCompare("tue_show", 1);
            for (int k = 0; k < 4; k++) if (an_n[k] === 1'b0) seen[k] = seg_n;
        end
        total++; if (seen[3] !== 7'h07) begin bad++; $display("FAIL tue_T seg_n=%h want 07", seen[3]); end
        total++; if (seen[2] !== 7'h41) begin bad++; $display("FAIL tue_U seg_n=%h want 41", seen[2]); end
        total++; if (seen[1] !== 7'h06) begin bad++; $display("FAIL tue_E seg_n=%h want 06", seen[1]); end
        total++; if (seen[0] !== 7'h7F) begin bad++; $display("FAIL tue_space seg_n=%h want 7f", seen[0]); end
    endtask

    task automatic test_two_loads();
        while (cyc % FRAME_LEN != 5) runCompare("two_wait", 1);
        setLetters(4'd8, 4'd7, 4'd0, 4'd0);
        load = 1'b1; tick(); load = 1'b0;
        runCompare("two_mid", 9);
        setLetters(4'd4, 4'd10, 4'd6, 4'd0);
        load = 1'b1; tick(); load = 1'b0;
        runCompare("two_show", 2 * FRAME_LEN);
    endtask

    task automatic test_boundary_load();
        while (cyc % FRAME_LEN != FRAME_LEN - 1) runCompare("bnd_wait", 1);
        setLetters(4'd9, 4'd1, 4'd5, 4'd11);
        load = 1'b1; tick(); load = 1'b0;
        for (int i = 0; i < GUARD; i++) begin
            tick();
            total++;
            if (an_n !== 4'hF) begin bad++; $display("FAIL bnd_guard an_n=%b want 1111", an_n); end
        end
        tick();
        total++;
        if (an_n !== 4'b0111 || seg_n !== 7'h0C) begin
            bad++;
            $display("FAIL bnd_latency an_n=%b want 0111 seg_n=%h want 0c", an_n, seg_n);
        end
        runCompare("bnd_after", FRAME_LEN);
    endtask

    task automatic test_dash_blank();
        setLetters(4'd15, 4'd14, 4'd1, 4'd2);
        load = 1'b1; tick(); load = 1'b0;
        runCompare("dash", FRAME_LEN + 4);
        blank = 1'b1;
        runCompare("blank", 20 + $urandom_range(0, 15));
        blank = 1'b0;
        runCompare("unblank", FRAME_LEN + 3);
    endtask

    task automatic test_mid_reset();
        setLetters(4'd12, 4'd5, 4'd13, 4'd0);
        load = 1'b1; tick(); load = 1'b0;
        runCompare("mrst_pre", FRAME_LEN + 13);
        #3 reset = 1'b1;
        #1;
        total++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || frame !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset an_n=%b want 1111 seg_n=%h want 7f frame=%b want 0", an_n, seg_n, frame);
        end
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        runCompare("mrst_post", FRAME_LEN + 5);
    endtask

    task automatic test_blink_edit();
`ifdef DAY_DISPLAY_BLINK_EN
        int litFrames2to3 = 0;
        edit = 1'b1;
        doReset();
        setLetters(4'd3, 4'd5, 4'd6, 4'd1);
        load = 1'b1; tick(); load = 1'b0;
        for (int i = 0; i < 8 * FRAME_LEN; i++) begin
            runCompare("blink", 1);
            if (cyc > 2 * FRAME_LEN + 1 && cyc <= 4 * FRAME_LEN && seg_n !== 7'h7F) litFrames2to3++;
        end
        total++;
        if (litFrames2to3 !== 0) begin bad++; $display("FAIL blink_off lit=%0d want 0", litFrames2to3); end
        runCompare("blink_pre", 2 * FRAME_LEN + 10);
        #3 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        load = 1'b1; tick(); load = 1'b0;
        runCompare("blink_rst", 2 * FRAME_LEN);
        runCompare("blink_off2", FRAME_LEN);
        edit = 1'b0;
        runCompare("blink_drop", FRAME_LEN);
`else
        edit = 1'b1;
        setLetters(4'd3, 4'd5, 4'd6, 4'd1);
        load = 1'b1; tick(); load = 1'b0;
        runCompare("edit_ignored", 6 * FRAME_LEN);
        edit = 1'b0;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            load = ($urandom_range(0, 15) == 0);
            setLetters(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 40) == 0) blank = !blank;
            if ($urandom_range(0, 60) == 0) edit = !edit;
            runCompare("random", 1);
        end
        load = 1'b0; blank = 1'b0; edit = 1'b0;
        runCompare("random_tail", FRAME_LEN);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_scan();
        test_load_mid_frame();
        test_two_loads();
        test_boundary_load();
        test_dash_blank();
        test_mid_reset();
        test_blink_edit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
